// File: rtl/fnd_count_scan.sv
// Digit-scan select and run/stop/clear stopwatch count source for the FND display controller.
// Optional down counting via `mode` when FND_DOWN_MODE_EN is defined.
module fnd_count_scan #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int COUNT_HZ  = 10,
  parameter int MAX_COUNT = 511
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clear,
`ifdef FND_DOWN_MODE_EN
  input  logic       mode,
`endif
  output logic [1:0] digit_sel,
  output logic [8:0] count,
  output logic       running
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT_DIV - 1);
  localparam logic [8:0]        MAX_VAL   = 9'(MAX_COUNT);

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bit 0 = run button, bit 1 = clear button
  logic [1:0]        btn_sync1_r;
  logic [1:0]        btn_sync2_r;
  logic [1:0]        btn_dly_r;
  logic [1:0]        btn_pulse_s;
  logic              run_pulse_s;
  logic              clr_pulse_s;
  logic              down_s;

  logic [SCAN_W-1:0] scan_presc_r;
  logic [1:0]        digit_sel_r;
  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic              running_r;
  logic [CNT_W-1:0]  cnt_presc_r;
  logic [CNT_W-1:0]  cnt_presc_nxt_s;
  logic [8:0]        count_r;
  logic [8:0]        count_nxt_s;

  function automatic logic [8:0] next_count(input logic [8:0] cur, input logic down);
    logic [8:0] res;
    if (down) begin
      if (cur == 9'd0) res = MAX_VAL;
      else             res = cur - 9'd1;
    end else begin
      if (cur == MAX_VAL) res = 9'd0;
      else                res = cur + 9'd1;
    end
    return res;
  endfunction

`ifdef FND_DOWN_MODE_EN
  assign down_s = mode;
`else
  assign down_s = 1'b0;
`endif

  assign btn_pulse_s = btn_sync2_r & ~btn_dly_r;
  assign run_pulse_s = btn_pulse_s[0];
  assign clr_pulse_s = btn_pulse_s[1];

  // Two-flop synchroniser plus delay stage for rise detection on both buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1_r <= 2'b00;
      btn_sync2_r <= 2'b00;
      btn_dly_r   <= 2'b00;
    end else begin
      btn_sync1_r <= {btn_clear, btn_run};
      btn_sync2_r <= btn_sync1_r;
      btn_dly_r   <= btn_sync2_r;
    end
  end

  // Free-running scan prescaler advancing the digit select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_presc_r <= {SCAN_W{1'b0}};
      digit_sel_r  <= 2'd0;
    end else if (scan_presc_r == SCAN_LAST) begin
      scan_presc_r <= {SCAN_W{1'b0}};
      digit_sel_r  <= digit_sel_r + 2'd1;
    end else begin
      scan_presc_r <= scan_presc_r + SCAN_W'(1);
      digit_sel_r  <= digit_sel_r;
    end
  end

  // Run/stop toggle on each run pulse
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_STOP: begin
        if (run_pulse_s) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_STOP;
      end
      ST_RUN: begin
        if (run_pulse_s) state_nxt_s = ST_STOP;
        else             state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_STOP;
    endcase
  end

  // Count prescaler holds in STOP so a pause keeps its phase; clear overrides a step
  always_comb begin
    cnt_presc_nxt_s = cnt_presc_r;
    count_nxt_s     = count_r;
    if (clr_pulse_s) begin
      cnt_presc_nxt_s = {CNT_W{1'b0}};
      count_nxt_s     = 9'd0;
    end else if (state_r == ST_RUN) begin
      if (cnt_presc_r == CNT_LAST) begin
        cnt_presc_nxt_s = {CNT_W{1'b0}};
        count_nxt_s     = next_count(count_r, down_s);
      end else begin
        cnt_presc_nxt_s = cnt_presc_r + CNT_W'(1);
        count_nxt_s     = count_r;
      end
    end else begin
      cnt_presc_nxt_s = cnt_presc_r;
      count_nxt_s     = count_r;
    end
  end

  // State, count and registered running flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_STOP;
      running_r   <= 1'b0;
      cnt_presc_r <= {CNT_W{1'b0}};
      count_r     <= 9'd0;
    end else begin
      state_r     <= state_nxt_s;
      running_r   <= (state_nxt_s == ST_RUN);
      cnt_presc_r <= cnt_presc_nxt_s;
      count_r     <= count_nxt_s;
    end
  end

  assign digit_sel = digit_sel_r;
  assign count     = count_r;
  assign running   = running_r;

endmodule

// File: doc/fnd_count_scan.md
# fnd_count_scan

Upstream driver for the four-digit FND display controller. Generates the free-running 2-bit digit-scan select and a 9-bit stopwatch-style count value, which feed that controller's digit-select and value inputs. Two raw push-button levels control the count: run/stop toggle and clear. The buttons are synchronised and edge-detected internally.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `SCAN_HZ`, 1000: digit-advance rate. `SCAN_DIV = CLK_HZ/SCAN_HZ`, which must be ≥2.
- `COUNT_HZ`, 10: count increment rate while running. `COUNT_DIV = CLK_HZ/COUNT_HZ`, which must be ≥2.
- `MAX_COUNT`, 511: last count value before wrap. Must be ≤511.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_run`  in  1  raw run/stop button level, asynchronous to `clk`.
- `btn_clear`  in  1  raw clear button level, asynchronous to `clk`.
- `mode`  in  1  count direction, 0 = up, 1 = down. Present only with `FND_DOWN_MODE_EN`.
- `digit_sel`  out  2  digit select for the display controller; 0 = ones … 3 = thousands.
- `count`  out  9  binary value to display.
- `running`  out  1  1 in state RUN.

## Operation
- **Reset values.** `digit_sel`=0, `count`=0, `running`=0, state STOP. Both prescalers are 0. Synchroniser and edge registers are 0.
- **Button input path.** Each button goes through a 2-FF synchroniser, then a delay register. A rise pulse is `sync2 & ~sync2_d`, one cycle wide. Holding a button produces exactly one pulse.
- **Scan prescaler.**
  - Counts 0..SCAN_DIV-1 in every state.
  - At SCAN_DIV-1 it returns to 0 and `digit_sel` increments modulo 4 (3→0).
  - Unaffected by buttons.
- **State machine.** Two states: STOP and RUN.
  - In STOP, a run pulse moves to RUN.
  - In RUN, a run pulse moves to STOP.
  - `running` is 1 in RUN, 0 in STOP (registered state).
- **Count prescaler.**
  - Advances 0..COUNT_DIV-1 only in RUN.
  - Holds its value in STOP, so pause/resume preserves phase.
  - When it reaches COUNT_DIV-1 in RUN, it returns to 0 and `count` steps.
- **Count step (up).** `count` = `count`+1. When `count`==MAX_COUNT, the next value is 0.
- **Clear pulse.** On the next edge, `count`=0 and the count prescaler =0. State is unchanged.
- **Priority.** Clear beats a count step in the same cycle.
- **Simultaneous run and clear pulses.** Both take effect: state toggles and count clears.
- **Reset mid-operation.** Asynchronous return to all reset values, regardless of state or pending pulses.

## Timing
- **Button latency.**
  - The button is high at setup of rising edge E1.
  - sync1 captures at E1; sync2 at E2; the pulse is high between E2 and E3.
  - `running` / `count` clear are visible after E3, i.e. 3 cycles.
- **`digit_sel` cadence.** First change at edge SCAN_DIV after reset release, then every SCAN_DIV cycles.
- **First count step after entering RUN** with the prescaler at 0: COUNT_DIV edges after the edge that set `running`.
- **Output registering.** All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`FND_DOWN_MODE_EN` defined.**
  - `mode` port exists.
  - `mode`=1 makes a count step `count`-1, with 0→MAX_COUNT wrap.
  - `mode` is sampled directly at each step and may change at any time; clear still forces 0.
- **`FND_DOWN_MODE_EN` undefined.** `mode` port is absent and the block counts up only.

## Test plan
Sim parameters: CLK_HZ=1000, SCAN_HZ=250 (SCAN_DIV=4), COUNT_HZ=100 (COUNT_DIV=10), MAX_COUNT=12.

- **Reset and scan.** Reset released, no buttons → `digit_sel` sequence 0,1,2,3,0 changing every 4 cycles; `count`=0; `running`=0 throughout.
- **Start and count.** Pulse `btn_run` high for 20 cycles → `running`=1 three cycles after assertion; exactly one toggle; `count` reaches 1 ten cycles later, then steps every 10 cycles.
- **Wrap.** Run 130 cycles from 0 → `count` 12 then 0; no value 13 appears.
- **Pause / resume.** Stop at prescaler 6, wait 50 cycles, restart → `count` frozen while stopped; next step 4 cycles after `running` returns to 1.
- **Clear collides with step, and with run.**
  - Clear pulse lands on the same edge as a step → `count`=0 and `running` unchanged.
  - Run and clear asserted together → `running` toggles and `count`=0.
- **Down mode and async reset.** With `FND_DOWN_MODE_EN`, `mode`=1 from 0 → next step gives 12. Assert `rst_n` low mid-count → all outputs 0 immediately, without a clock edge.
